// File: rtl/mem_arbiter_if.sv
// Bundle of the IFU and LSU request/response channels plus the memory port of mem_arbiter.
// The slave modport is the arbiter's view; master is the view of the stages and memory model around it.
interface mem_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  localparam int MASK_W = DATA_W / 8;

  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [ADDR_W-1:0] ifu_req_addr;
  logic              ifu_rsp_valid;
  logic              ifu_rsp_ready;
  logic [DATA_W-1:0] ifu_rsp_data;

  logic              lsu_req_valid;
  logic              lsu_req_ready;
  logic [ADDR_W-1:0] lsu_req_addr;
  logic              lsu_req_we;
  logic [DATA_W-1:0] lsu_req_wdata;
  logic [MASK_W-1:0] lsu_req_wmask;
  logic              lsu_rsp_valid;
  logic              lsu_rsp_ready;
  logic [DATA_W-1:0] lsu_rsp_data;

  logic              mem_ce;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_req_addr, ifu_rsp_ready,
    input  lsu_req_valid, lsu_req_addr, lsu_req_we, lsu_req_wdata, lsu_req_wmask, lsu_rsp_ready,
    input  mem_rdata,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
    output lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
    output mem_ce, mem_we, mem_addr, mem_wdata, mem_wmask
  );

  modport master (
    output ifu_req_valid, ifu_req_addr, ifu_rsp_ready,
    output lsu_req_valid, lsu_req_addr, lsu_req_we, lsu_req_wdata, lsu_req_wmask, lsu_rsp_ready,
    output mem_rdata,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_data,
    input  mem_ce, mem_we, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one combinational memory port between IFU and LSU,
// with a single outstanding transaction and a configurable response latency (1..15).
module mem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam int MASK_W = DATA_W / 8;
  // WAIT covers LATENCY-1 cycles; the counter is preloaded so that zero marks its last cycle.
  localparam logic [3:0] WAIT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef enum logic {SEL_IFU, SEL_LSU} sel_t;

  state_t            state;
  sel_t              last_grant;
  logic [3:0]        wait_cnt;
  logic              req_we;

  logic              grant_ifu;
  logic              grant_lsu;
  logic [ADDR_W-1:0] acc_addr;
  logic              acc_we;
  logic [DATA_W-1:0] acc_wdata;
  logic [MASK_W-1:0] acc_wmask;
  logic [DATA_W-1:0] capture_data;
  logic              rsp_done;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    grant_ifu = bus.ifu_req_valid & (~bus.lsu_req_valid | (last_grant == SEL_LSU));
    grant_lsu = bus.lsu_req_valid & (~bus.ifu_req_valid | (last_grant == SEL_IFU));
  end

  assign bus.ifu_req_ready = (state == IDLE) & grant_ifu;
  assign bus.lsu_req_ready = (state == IDLE) & grant_lsu;

  // Fields of the request being accepted; IFU traffic is always a read with an empty mask.
  always_comb begin
    acc_addr  = bus.lsu_req_addr;
    acc_we    = bus.lsu_req_we;
    acc_wdata = bus.lsu_req_wdata;
    acc_wmask = bus.lsu_req_wmask;
    if (grant_ifu) begin
      acc_addr  = bus.ifu_req_addr;
      acc_we    = 1'b0;
      acc_wdata = '0;
      acc_wmask = '0;
    end
  end

  assign capture_data = req_we ? '0 : bus.mem_rdata;
  assign rsp_done     = (bus.ifu_rsp_valid & bus.ifu_rsp_ready) |
                        (bus.lsu_rsp_valid & bus.lsu_rsp_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      last_grant        <= SEL_LSU;
      wait_cnt          <= '0;
      req_we            <= 1'b0;
      bus.mem_ce        <= 1'b0;
      bus.mem_we        <= 1'b0;
      bus.mem_addr      <= '0;
      bus.mem_wdata     <= '0;
      bus.mem_wmask     <= '0;
      bus.ifu_rsp_valid <= 1'b0;
      bus.ifu_rsp_data  <= '0;
      bus.lsu_rsp_valid <= 1'b0;
      bus.lsu_rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_ifu | grant_lsu) begin
            last_grant    <= grant_ifu ? SEL_IFU : SEL_LSU;
            req_we        <= acc_we;
            bus.mem_ce    <= 1'b1;
            bus.mem_we    <= acc_we;
            bus.mem_addr  <= acc_addr;
            bus.mem_wdata <= acc_wdata;
            bus.mem_wmask <= acc_wmask;
            state         <= ISSUE;
          end
        end

        ISSUE: begin
          bus.mem_ce <= 1'b0;
          bus.mem_we <= 1'b0;
          if (last_grant == SEL_IFU) begin
            bus.ifu_rsp_data <= capture_data;
          end else begin
            bus.lsu_rsp_data <= capture_data;
          end
          if (LATENCY > 1) begin
            wait_cnt <= WAIT_INIT;
            state    <= WAIT;
          end else begin
            bus.ifu_rsp_valid <= (last_grant == SEL_IFU);
            bus.lsu_rsp_valid <= (last_grant == SEL_LSU);
            state             <= RESP;
          end
        end

        WAIT: begin
          if (wait_cnt == 4'd0) begin
            bus.ifu_rsp_valid <= (last_grant == SEL_IFU);
            bus.lsu_rsp_valid <= (last_grant == SEL_LSU);
            state             <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        RESP: begin
          // Returning to IDLE only after the handshake keeps a new accept out of this cycle.
          if (rsp_done) begin
            bus.ifu_rsp_valid <= 1'b0;
            bus.lsu_rsp_valid <= 1'b0;
            state             <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: one instance with LATENCY=1 and one with
// LATENCY=3, both fed the same request/response-ready stimulus and each with its own memory model.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   numChecks;
  int   numFails;

  mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) busA ();
  mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) busB ();

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .LATENCY(1)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (busA)
  );

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .LATENCY(3)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (busB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory content: one fixed word at the boot address, otherwise a pattern of the address.
  function automatic logic [63:0] memModel(input logic [63:0] addr);
    if (addr == 64'h8000_0000) return 64'h1234;
    return addr ^ 64'h5a5a_0000_0000_a5a5;
  endfunction

  always_comb busA.mem_rdata = busA.mem_ce ? memModel(busA.mem_addr) : 64'h0;
  always_comb busB.mem_rdata = busB.mem_ce ? memModel(busB.mem_addr) : 64'h0;

  assign busB.ifu_req_valid = busA.ifu_req_valid;
  assign busB.ifu_req_addr  = busA.ifu_req_addr;
  assign busB.ifu_rsp_ready = busA.ifu_rsp_ready;
  assign busB.lsu_req_valid = busA.lsu_req_valid;
  assign busB.lsu_req_addr  = busA.lsu_req_addr;
  assign busB.lsu_req_we    = busA.lsu_req_we;
  assign busB.lsu_req_wdata = busA.lsu_req_wdata;
  assign busB.lsu_req_wmask = busA.lsu_req_wmask;
  assign busB.lsu_rsp_ready = busA.lsu_rsp_ready;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    numChecks++;
    if (observed !== expected) begin
      numFails++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ifuV, input logic [63:0] ifuAddr,
                               input logic lsuV, input logic lsuWe, input logic [63:0] lsuAddr,
                               input logic [63:0] lsuWdata, input logic [7:0] lsuWmask);
    busA.ifu_req_valid = ifuV;
    busA.ifu_req_addr  = ifuAddr;
    busA.lsu_req_valid = lsuV;
    busA.lsu_req_we    = lsuWe;
    busA.lsu_req_addr  = lsuAddr;
    busA.lsu_req_wdata = lsuWdata;
    busA.lsu_req_wmask = lsuWmask;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00);
  endtask

  logic grants [4];
  int   grantCount;
  logic expGrants [4];

  initial begin
    numChecks = 0;
    numFails  = 0;
    rst = 1'b1;
    busA.ifu_rsp_ready = 1'b1;
    busA.lsu_rsp_ready = 1'b1;
    idleInputs();
    tick();
    tick();

    $display("[TB] reset state");
    checkOutput("rst ifu_rsp_valid", 64'(busA.ifu_rsp_valid), 64'h0);
    checkOutput("rst lsu_rsp_valid", 64'(busA.lsu_rsp_valid), 64'h0);
    checkOutput("rst mem_ce", 64'(busA.mem_ce), 64'h0);
    checkOutput("rst mem_addr", busA.mem_addr, 64'h0);
    rst = 1'b0;

    $display("[TB] IFU read, latency 1 and 3");
    applyStimulus(1'b1, 64'h8000_0000, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00);
    checkOutput("t1 ifu_req_ready", 64'(busA.ifu_req_ready), 64'h1);
    checkOutput("t1 lsu_req_ready", 64'(busA.lsu_req_ready), 64'h0);
    tick();
    idleInputs();
    checkOutput("t1 mem_ce N+1", 64'(busA.mem_ce), 64'h1);
    checkOutput("t1 mem_addr", busA.mem_addr, 64'h8000_0000);
    checkOutput("t1 mem_we", 64'(busA.mem_we), 64'h0);
    checkOutput("t1 ifu_rsp_valid N+1", 64'(busA.ifu_rsp_valid), 64'h0);
    checkOutput("t5 mem_ce N+1", 64'(busB.mem_ce), 64'h1);
    tick();
    checkOutput("t1 mem_ce N+2", 64'(busA.mem_ce), 64'h0);
    checkOutput("t1 ifu_rsp_valid N+2", 64'(busA.ifu_rsp_valid), 64'h1);
    checkOutput("t1 ifu_rsp_data", busA.ifu_rsp_data, 64'h1234);
    checkOutput("t1 lsu_rsp_valid", 64'(busA.lsu_rsp_valid), 64'h0);
    checkOutput("t5 mem_ce N+2", 64'(busB.mem_ce), 64'h0);
    checkOutput("t5 ifu_rsp_valid N+2", 64'(busB.ifu_rsp_valid), 64'h0);
    tick();
    checkOutput("t1 ifu_rsp_valid after hs", 64'(busA.ifu_rsp_valid), 64'h0);
    checkOutput("t5 ifu_rsp_valid N+3", 64'(busB.ifu_rsp_valid), 64'h0);
    tick();
    checkOutput("t5 ifu_rsp_valid N+4", 64'(busB.ifu_rsp_valid), 64'h1);
    checkOutput("t5 ifu_rsp_data", busB.ifu_rsp_data, 64'h1234);
    tick();
    tick();

    $display("[TB] LSU write");
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b1, 64'h8000_0010, 64'hdead_beef, 8'h0f);
    checkOutput("t2 lsu_req_ready", 64'(busA.lsu_req_ready), 64'h1);
    tick();
    idleInputs();
    checkOutput("t2 mem_ce", 64'(busA.mem_ce), 64'h1);
    checkOutput("t2 mem_we", 64'(busA.mem_we), 64'h1);
    checkOutput("t2 mem_addr", busA.mem_addr, 64'h8000_0010);
    checkOutput("t2 mem_wdata", busA.mem_wdata, 64'hdead_beef);
    checkOutput("t2 mem_wmask", 64'(busA.mem_wmask), 64'h0f);
    tick();
    checkOutput("t2 mem_ce off", 64'(busA.mem_ce), 64'h0);
    checkOutput("t2 lsu_rsp_valid", 64'(busA.lsu_rsp_valid), 64'h1);
    checkOutput("t2 lsu_rsp_data", busA.lsu_rsp_data, 64'h0);
    checkOutput("t2 ifu_rsp_valid", 64'(busA.ifu_rsp_valid), 64'h0);
    tick();
    checkOutput("t2 lsu_rsp_valid after hs", 64'(busA.lsu_rsp_valid), 64'h0);
    tick();
    tick();
    tick();

    $display("[TB] response backpressure");
    busA.ifu_rsp_ready = 1'b0;
    applyStimulus(1'b1, 64'h8000_0020, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00);
    checkOutput("t4 ifu_req_ready", 64'(busA.ifu_req_ready), 64'h1);
    tick();
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0, 64'h8000_0040, 64'h0, 8'h00);
    checkOutput("t4 mem_ce issue", 64'(busA.mem_ce), 64'h1);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("t4 hold ifu_rsp_valid", 64'(busA.ifu_rsp_valid), 64'h1);
      checkOutput("t4 hold ifu_rsp_data", busA.ifu_rsp_data, 64'h5a5a_0000_8000_a585);
      checkOutput("t4 hold mem_ce", 64'(busA.mem_ce), 64'h0);
      checkOutput("t4 hold lsu_req_ready", 64'(busA.lsu_req_ready), 64'h0);
      tick();
    end
    busA.ifu_rsp_ready = 1'b1;
    #1;
    checkOutput("t4 hs cycle lsu_req_ready", 64'(busA.lsu_req_ready), 64'h0);
    tick();
    checkOutput("t4 ifu_rsp_valid after hs", 64'(busA.ifu_rsp_valid), 64'h0);
    checkOutput("t4 lsu_req_ready idle", 64'(busA.lsu_req_ready), 64'h1);
    tick();
    idleInputs();
    for (int i = 0; i < 10; i++) tick();

    $display("[TB] round-robin from reset");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 64'h8000_0100, 1'b1, 1'b0, 64'h8000_0200, 64'h0, 8'h00);
    expGrants = '{1'b0, 1'b1, 1'b0, 1'b1};
    grantCount = 0;
    for (int i = 0; i < 60 && grantCount < 4; i++) begin
      if (busA.ifu_req_ready && busA.lsu_req_ready) begin
        checkOutput("t3 both ready", 64'h1, 64'h0);
      end
      if (busA.ifu_req_ready) begin
        grants[grantCount] = 1'b0;
        grantCount++;
      end else if (busA.lsu_req_ready) begin
        grants[grantCount] = 1'b1;
        grantCount++;
      end
      tick();
    end
    checkOutput("t3 grant count", 64'(grantCount), 64'd4);
    for (int k = 0; k < grantCount; k++) begin
      checkOutput("t3 grant order", 64'(grants[k]), 64'(expGrants[k]));
    end
    idleInputs();
    for (int i = 0; i < 10; i++) tick();

    $display("[TB] reset during WAIT");
    applyStimulus(1'b1, 64'h8000_0000, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00);
    checkOutput("t6 ifu_req_ready", 64'(busB.ifu_req_ready), 64'h1);
    tick();
    idleInputs();
    tick();
    checkOutput("t6 in wait mem_ce", 64'(busB.mem_ce), 64'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t6 ifu_rsp_valid", 64'(busB.ifu_rsp_valid), 64'h0);
    checkOutput("t6 lsu_rsp_valid", 64'(busB.lsu_rsp_valid), 64'h0);
    checkOutput("t6 mem_ce", 64'(busB.mem_ce), 64'h0);
    applyStimulus(1'b1, 64'h8000_0300, 1'b1, 1'b0, 64'h8000_0400, 64'h0, 8'h00);
    checkOutput("t6 tie ifu_req_ready", 64'(busB.ifu_req_ready), 64'h1);
    checkOutput("t6 tie lsu_req_ready", 64'(busB.lsu_req_ready), 64'h0);
    idleInputs();
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("t6 no aborted rsp", 64'(busB.ifu_rsp_valid), 64'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
